usb_rx_packet_parser: RTL and testbench
=======================================

// Module: usb_rx_packet_parser
// PURPOSE
//  Byte-level packet parser downstream of the SIE receive interface. Consumes the PID+body+CRC byte stream, checks the PID,
//  classifies token/SOF/handshake/data packets, extracts address, endpoint and frame fields, and forwards DATAx payload with
//  the 2 CRC16 bytes stripped. Feeds the protocol engine; all signals in the clk48_i domain.
// PARAMETERS
//  MAX_PAYLOAD  1023  max payload bytes accepted per DATAx packet; more -> length error
// PORTS
//  clk48_i          in   1   48 MHz system clock
//  rstn_i           in   1   asynchronous active-low reset
//  usbRst_i         in   1   synchronous abort (USB bus reset seen): drop current packet
//  rxAcceptNewData_o out 1   ready toward SIE
//  rxDataValid_i    in   1   SIE byte valid
//  rxData_i         in   8   SIE byte
//  rxIsLastByte_i   in   1   SIE: current byte is last of packet
//  keepPacket_i     in   1   SIE: no rx error; sampled with last byte
//  tokValid_o       out  1   1-cycle pulse: token/SOF decoded OK
//  tokPid_o         out  4   PID[3:0] of token (OUT/IN/SETUP/SOF/PING)
//  tokAddr_o        out  7   device address (b1[6:0])
//  tokEndp_o        out  4   endpoint {b2[2:0], b1[7]}
//  sofFrame_o       out  11  frame number {b2[2:0], b1}; valid with tokValid_o when tokPid_o==SOF
//  hsValid_o        out  1   1-cycle pulse: handshake PID received
//  hsPid_o          out  4   ACK/NAK/STALL/NYET
//  dataPid_o        out  4   DATA0/1/2/MDATA; stable from PID accept until pktDone_o
//  payValid_o       out  1   payload byte valid
//  payReady_i       in   1   consumer ready
//  payData_o        out  8   payload byte
//  payLast_o        out  1   last payload byte
//  pktDone_o        out  1   1-cycle pulse: DATAx packet ended
//  pktOk_o          out  1   with pktDone_o: 1=keep, 0=discard forwarded payload
//  pktErr_o         out  1   1-cycle pulse: any packet dropped (PID, length, SIE error, overflow)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; buffer empty; rxAcceptNewData_o=0 while rstn_i low, 1 in IDLE.
//  Byte accepted on rxDataValid_i && rxAcceptNewData_o. PID ok iff rxData_i[7:4]==~rxData_i[3:0].
//  FSM: IDLE -PID ok,token-> TOK1 -> TOK2 ; -handshake-> HS_END ; -DATAx-> DATA ; -bad PID/reserved-> DRAIN.
//   TOK2: byte must carry rxIsLastByte_i; on it, if keepPacket_i pulse tokValid_o else pktErr_o; -> IDLE.
//   Token shorter (last at TOK1) or longer (TOK2 byte not last) -> pktErr_o, DRAIN/IDLE.
//   Handshake: PID byte must itself be last and keepPacket_i=1 -> hsValid_o; else pktErr_o.
//   DATA: bytes enter 3-entry delay line (usb_rx_crc_strip); oldest emitted when 4th arrives. On last byte: if >=2 bytes
//     buffered after it, the newest 2 are CRC and discarded, remaining tail byte emitted with payLast_o, then pktDone_o
//     one cycle after the payLast handshake. Zero-length (PID+2 CRC): no payload beat, pktDone_o pktOk_o=keepPacket_i.
//     Fewer than 2 body bytes -> pktErr_o, pktDone_o with pktOk_o=0.
//   DRAIN: accept and discard until rxIsLastByte_i -> IDLE. pktErr_o pulses once per dropped packet, on entry.
//  Backpressure: rxAcceptNewData_o=0 while delay line full and payValid_o && !payReady_i; payload stable while stalled.
//  pktOk_o = keepPacket_i (captured at last byte) && no overflow. Payload >MAX_PAYLOAD -> stop forwarding, DRAIN,
//   pktDone_o pktOk_o=0, pktErr_o.
//  Byte with rxIsLastByte_i in IDLE (1-byte non-handshake): pktErr_o, stay IDLE.
//  usbRst_i (highest priority, same cycle): FSM->IDLE, buffer flushed, payValid_o=0, no pktDone_o/pktErr_o.
//  Async reset mid-packet: immediate clear; no outputs until next PID.
// CONFIGURATION
//  USB_RX_PARSER_ERR_CNT_EN defined: adds outputs pidErrCnt_o[7:0], lenErrCnt_o[7:0], rxErrCnt_o[7:0] (saturating,
//   cleared by rstn_i/usbRst_i). Undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
//  sie_defs_pkg: PID code localparams/enum (tokens, data, handshakes, SPECIAL), parser state enum, field width constants.
//  Sub-module usb_rx_crc_strip: 3-entry byte delay line with count, push/pop, flush.
// TESTING
//  SETUP 0x2D,0x05,0xE8 (last, keep=1) -> tokValid_o pulse, tokAddr_o=5, tokEndp_o=0, no pktErr_o.
//  SOF 0xA5,0x34,0x12 -> tokValid_o, sofFrame_o=0x234.
//  DATA1 0x4B,0x11,0x22,0x33,CRC,CRC keep=1, payReady_i toggling -> payload 11,22,33, payLast_o on 33, pktDone_o pktOk_o=1.
//  DATA0 0xC3,CRC,CRC -> no payValid_o, pktDone_o pktOk_o=1; same with keep=0 -> pktOk_o=0.
//  Bad PID 0x2E + 2 bytes -> single pktErr_o, bytes drained, next ACK 0xD2 (last) -> hsValid_o hsPid_o=0x2.
//  usbRst_i mid DATA payload -> payValid_o=0 next cycle, no pktDone_o, following token parsed correctly.

Source files
------------

// File: rtl/sie_defs_pkg.sv
// PID codes, PID classification, parser state encoding and field widths shared by
// the USB receive packet parser and its helpers.
package sie_defs_pkg;

  localparam int unsigned PID_W   = 4;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned ENDP_W  = 4;
  localparam int unsigned FRAME_W = 11;

  typedef enum logic [PID_W-1:0] {
    PID_RSVD  = 4'h0,
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_PING  = 4'h4,
    PID_SOF   = 4'h5,
    PID_NYET  = 4'h6,
    PID_DATA2 = 4'h7,
    PID_SPLIT = 4'h8,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_PRE   = 4'hC,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE,
    PID_MDATA = 4'hF
  } pid_e;

  typedef enum logic [1:0] {
    PK_BAD,
    PK_TOKEN,
    PK_DATA,
    PK_HS
  } pid_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOK1,
    ST_TOK2,
    ST_DATA,
    ST_DATA_END,
    ST_DATA_LAST,
    ST_DRAIN
  } parser_state_e;

  // A PID byte is only trusted when its upper nibble is the complement of the lower one.
  function automatic pid_kind_e pid_kind(input logic [7:0] b);
    pid_kind_e k;
    k = PK_BAD;
    if (b[7:4] == ~b[3:0]) begin
      case (pid_e'(b[3:0]))
        PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_PING: k = PK_TOKEN;
        PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA:    k = PK_DATA;
        PID_ACK, PID_NAK, PID_STALL, PID_NYET:         k = PK_HS;
        default:                                       k = PK_BAD;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/usb_rx_crc_strip.sv
// Three-entry byte delay line: holds back the newest bytes of a DATAx body so the
// trailing CRC16 can be discarded once the last byte is known.
module usb_rx_crc_strip (
  input  logic       clk48_i,
  input  logic       rstn_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  logic [7:0] data_i,
  output logic [7:0] head_o,
  output logic [1:0] count_o
);

  localparam int unsigned DEPTH = 3;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [1:0] cnt_q, cnt_d, cnt_mid;

  always_comb begin
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    cnt_mid = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      // Pop shifts first so a simultaneous push lands behind the surviving entries.
      if (pop_i && cnt_q != '0) begin
        mem_d[0] = mem_q[1];
        mem_d[1] = mem_q[2];
        cnt_mid  = cnt_q - 2'd1;
      end
      cnt_d = cnt_mid;
      if (push_i && cnt_mid != 2'd3) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (i == 32'(cnt_mid)) mem_d[i] = data_i;
        end
        cnt_d = cnt_mid + 2'd1;
      end
    end
  end

  always_ff @(posedge clk48_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[0];
  assign count_o = cnt_q;

endmodule

// File: rtl/usb_rx_packet_parser.sv
// Byte-level USB receive packet parser: PID check, token/SOF/handshake decode and DATAx
// payload forwarding with CRC16 stripped. Optional error counters: USB_RX_PARSER_ERR_CNT_EN.
module usb_rx_packet_parser
  import sie_defs_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 1023
) (
  input  logic               clk48_i,
  input  logic               rstn_i,
  input  logic               usbRst_i,
  output logic               rxAcceptNewData_o,
  input  logic               rxDataValid_i,
  input  logic [7:0]         rxData_i,
  input  logic               rxIsLastByte_i,
  input  logic               keepPacket_i,
  output logic               tokValid_o,
  output logic [PID_W-1:0]   tokPid_o,
  output logic [ADDR_W-1:0]  tokAddr_o,
  output logic [ENDP_W-1:0]  tokEndp_o,
  output logic [FRAME_W-1:0] sofFrame_o,
  output logic               hsValid_o,
  output logic [PID_W-1:0]   hsPid_o,
  output logic [PID_W-1:0]   dataPid_o,
  output logic               payValid_o,
  input  logic               payReady_i,
  output logic [7:0]         payData_o,
  output logic               payLast_o,
  output logic               pktDone_o,
  output logic               pktOk_o,
`ifdef USB_RX_PARSER_ERR_CNT_EN
  output logic [7:0]         pidErrCnt_o,
  output logic [7:0]         lenErrCnt_o,
  output logic [7:0]         rxErrCnt_o,
`endif
  output logic               pktErr_o
);

  localparam int unsigned        CNT_W   = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CNT_W-1:0]   PAY_MAX = CNT_W'(MAX_PAYLOAD);

  parser_state_e      state_q, state_d;
  logic               out_en_q;
  logic [PID_W-1:0]   cur_pid_q, cur_pid_d;
  logic [7:0]         b1_q, b1_d;
  logic               keep_q, keep_d;
  logic [CNT_W-1:0]   pay_cnt_q, pay_cnt_d;

  logic               tok_valid_q, tok_valid_d;
  logic [PID_W-1:0]   tok_pid_q, tok_pid_d;
  logic [ADDR_W-1:0]  tok_addr_q, tok_addr_d;
  logic [ENDP_W-1:0]  tok_endp_q, tok_endp_d;
  logic [FRAME_W-1:0] sof_frame_q, sof_frame_d;
  logic               hs_valid_q, hs_valid_d;
  logic [PID_W-1:0]   hs_pid_q, hs_pid_d;
  logic [PID_W-1:0]   data_pid_q, data_pid_d;
  logic               pay_valid_q, pay_valid_d;
  logic [7:0]         pay_data_q, pay_data_d;
  logic               pay_last_q, pay_last_d;
  logic               pkt_done_q, pkt_done_d;
  logic               pkt_ok_q, pkt_ok_d;
  logic               pkt_err_q, pkt_err_d;

  logic               buf_push, buf_pop, buf_flush;
  logic [7:0]         buf_head;
  logic [1:0]         buf_cnt;
  logic               rx_accept, rx_fire;
  pid_kind_e          kind;
  logic               pid_err_evt, len_err_evt, rx_err_evt;

  usb_rx_crc_strip u_crc_strip (
    .clk48_i (clk48_i),
    .rstn_i  (rstn_i),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .flush_i (buf_flush),
    .data_i  (rxData_i),
    .head_o  (buf_head),
    .count_o (buf_cnt)
  );

  // A new byte is refused only when it would need to pop into a stalled output.
  assign rx_accept = out_en_q && (state_q != ST_DATA_END) && (state_q != ST_DATA_LAST) &&
                     !((buf_cnt == 2'd3) && pay_valid_q && !payReady_i);
  assign rx_fire   = rxDataValid_i && rx_accept;
  assign kind      = pid_kind(rxData_i);

  always_comb begin
    state_d     = state_q;
    cur_pid_d   = cur_pid_q;
    b1_d        = b1_q;
    keep_d      = keep_q;
    pay_cnt_d   = pay_cnt_q;
    tok_valid_d = 1'b0;
    tok_pid_d   = tok_pid_q;
    tok_addr_d  = tok_addr_q;
    tok_endp_d  = tok_endp_q;
    sof_frame_d = sof_frame_q;
    hs_valid_d  = 1'b0;
    hs_pid_d    = hs_pid_q;
    data_pid_d  = data_pid_q;
    pay_valid_d = pay_valid_q && !payReady_i;
    pay_last_d  = pay_last_q && !payReady_i;
    pay_data_d  = pay_data_q;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    buf_push    = 1'b0;
    buf_pop     = 1'b0;
    buf_flush   = 1'b0;
    pid_err_evt = 1'b0;
    len_err_evt = 1'b0;
    rx_err_evt  = 1'b0;

    unique case (state_q)
      ST_IDLE: if (rx_fire) begin
        cur_pid_d = rxData_i[3:0];
        if (rxIsLastByte_i) begin
          if (kind == PK_HS && keepPacket_i) begin
            hs_valid_d = 1'b1;
            hs_pid_d   = rxData_i[3:0];
          end else begin
            pkt_err_d   = 1'b1;
            pid_err_evt = (kind == PK_BAD);
            rx_err_evt  = (kind == PK_HS);
            len_err_evt = (kind == PK_TOKEN) || (kind == PK_DATA);
          end
        end else begin
          unique case (kind)
            PK_TOKEN: state_d = ST_TOK1;
            PK_DATA: begin
              state_d    = ST_DATA;
              data_pid_d = rxData_i[3:0];
              pay_cnt_d  = '0;
            end
            default: begin
              state_d     = ST_DRAIN;
              pkt_err_d   = 1'b1;
              pid_err_evt = (kind == PK_BAD);
              len_err_evt = (kind == PK_HS);
            end
          endcase
        end
      end

      ST_TOK1: if (rx_fire) begin
        b1_d = rxData_i;
        if (rxIsLastByte_i) begin
          state_d     = ST_IDLE;
          pkt_err_d   = 1'b1;
          len_err_evt = 1'b1;
        end else begin
          state_d = ST_TOK2;
        end
      end

      ST_TOK2: if (rx_fire) begin
        if (rxIsLastByte_i) begin
          state_d = ST_IDLE;
          if (keepPacket_i) begin
            tok_valid_d = 1'b1;
            tok_pid_d   = cur_pid_q;
            tok_addr_d  = b1_q[6:0];
            tok_endp_d  = {rxData_i[2:0], b1_q[7]};
            sof_frame_d = {rxData_i[2:0], b1_q};
          end else begin
            pkt_err_d  = 1'b1;
            rx_err_evt = 1'b1;
          end
        end else begin
          state_d     = ST_DRAIN;
          pkt_err_d   = 1'b1;
          len_err_evt = 1'b1;
        end
      end

      ST_DATA: if (rx_fire) begin
        if (buf_cnt == 2'd3 && pay_cnt_q == PAY_MAX) begin
          buf_flush   = 1'b1;
          pay_valid_d = 1'b0;
          pay_last_d  = 1'b0;
          pkt_done_d  = 1'b1;
          pkt_err_d   = 1'b1;
          len_err_evt = 1'b1;
          state_d     = rxIsLastByte_i ? ST_IDLE : ST_DRAIN;
        end else if (rxIsLastByte_i && buf_cnt == 2'd0) begin
          pkt_done_d  = 1'b1;
          pkt_err_d   = 1'b1;
          len_err_evt = 1'b1;
          state_d     = ST_IDLE;
        end else if (rxIsLastByte_i && buf_cnt == 2'd1) begin
          buf_flush  = 1'b1;
          pkt_done_d = 1'b1;
          pkt_ok_d   = keepPacket_i;
          pkt_err_d  = !keepPacket_i;
          rx_err_evt = !keepPacket_i;
          state_d    = ST_IDLE;
        end else begin
          buf_push = 1'b1;
          if (buf_cnt == 2'd3) begin
            buf_pop     = 1'b1;
            pay_valid_d = 1'b1;
            pay_last_d  = 1'b0;
            pay_data_d  = buf_head;
            pay_cnt_d   = pay_cnt_q + CNT_W'(1);
          end
          if (rxIsLastByte_i) begin
            keep_d  = keepPacket_i;
            state_d = ST_DATA_END;
          end
        end
      end

      // Delay line now holds the tail payload byte followed by the two CRC bytes.
      ST_DATA_END: if (!pay_valid_q || payReady_i) begin
        buf_flush = 1'b1;
        if (pay_cnt_q == PAY_MAX) begin
          pay_valid_d = 1'b0;
          pkt_done_d  = 1'b1;
          pkt_err_d   = 1'b1;
          len_err_evt = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          pay_valid_d = 1'b1;
          pay_data_d  = buf_head;
          pay_last_d  = 1'b1;
          pay_cnt_d   = pay_cnt_q + CNT_W'(1);
          state_d     = ST_DATA_LAST;
        end
      end

      ST_DATA_LAST: if (pay_valid_q && payReady_i) begin
        pkt_done_d = 1'b1;
        pkt_ok_d   = keep_q;
        pkt_err_d  = !keep_q;
        rx_err_evt = !keep_q;
        state_d    = ST_IDLE;
      end

      ST_DRAIN: if (rx_fire && rxIsLastByte_i) state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (usbRst_i) begin
      state_d     = ST_IDLE;
      buf_flush   = 1'b1;
      buf_push    = 1'b0;
      buf_pop     = 1'b0;
      pay_valid_d = 1'b0;
      pay_last_d  = 1'b0;
      tok_valid_d = 1'b0;
      hs_valid_d  = 1'b0;
      pkt_done_d  = 1'b0;
      pkt_ok_d    = 1'b0;
      pkt_err_d   = 1'b0;
      pid_err_evt = 1'b0;
      len_err_evt = 1'b0;
      rx_err_evt  = 1'b0;
    end
  end

  always_ff @(posedge clk48_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      out_en_q    <= 1'b0;
      cur_pid_q   <= '0;
      b1_q        <= '0;
      keep_q      <= 1'b0;
      pay_cnt_q   <= '0;
      tok_valid_q <= 1'b0;
      tok_pid_q   <= '0;
      tok_addr_q  <= '0;
      tok_endp_q  <= '0;
      sof_frame_q <= '0;
      hs_valid_q  <= 1'b0;
      hs_pid_q    <= '0;
      data_pid_q  <= '0;
      pay_valid_q <= 1'b0;
      pay_data_q  <= '0;
      pay_last_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_en_q    <= 1'b1;
      cur_pid_q   <= cur_pid_d;
      b1_q        <= b1_d;
      keep_q      <= keep_d;
      pay_cnt_q   <= pay_cnt_d;
      tok_valid_q <= tok_valid_d;
      tok_pid_q   <= tok_pid_d;
      tok_addr_q  <= tok_addr_d;
      tok_endp_q  <= tok_endp_d;
      sof_frame_q <= sof_frame_d;
      hs_valid_q  <= hs_valid_d;
      hs_pid_q    <= hs_pid_d;
      data_pid_q  <= data_pid_d;
      pay_valid_q <= pay_valid_d;
      pay_data_q  <= pay_data_d;
      pay_last_q  <= pay_last_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

`ifdef USB_RX_PARSER_ERR_CNT_EN
  logic [7:0] pid_err_cnt_q, len_err_cnt_q, rx_err_cnt_q;

  always_ff @(posedge clk48_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pid_err_cnt_q <= '0;
      len_err_cnt_q <= '0;
      rx_err_cnt_q  <= '0;
    end else if (usbRst_i) begin
      pid_err_cnt_q <= '0;
      len_err_cnt_q <= '0;
      rx_err_cnt_q  <= '0;
    end else begin
      if (pid_err_evt && pid_err_cnt_q != '1) pid_err_cnt_q <= pid_err_cnt_q + 8'd1;
      if (len_err_evt && len_err_cnt_q != '1) len_err_cnt_q <= len_err_cnt_q + 8'd1;
      if (rx_err_evt && rx_err_cnt_q != '1)   rx_err_cnt_q  <= rx_err_cnt_q + 8'd1;
    end
  end

  assign pidErrCnt_o = pid_err_cnt_q;
  assign lenErrCnt_o = len_err_cnt_q;
  assign rxErrCnt_o  = rx_err_cnt_q;
`else
  logic unused_err_evt;
  assign unused_err_evt = ^{pid_err_evt, len_err_evt, rx_err_evt};
`endif

  assign rxAcceptNewData_o = rx_accept;
  assign tokValid_o        = tok_valid_q;
  assign tokPid_o          = tok_pid_q;
  assign tokAddr_o         = tok_addr_q;
  assign tokEndp_o         = tok_endp_q;
  assign sofFrame_o        = sof_frame_q;
  assign hsValid_o         = hs_valid_q;
  assign hsPid_o           = hs_pid_q;
  assign dataPid_o         = data_pid_q;
  assign payValid_o        = pay_valid_q;
  assign payData_o         = pay_data_q;
  assign payLast_o         = pay_last_q;
  assign pktDone_o         = pkt_done_q;
  assign pktOk_o           = pkt_ok_q;
  assign pktErr_o          = pkt_err_q;

endmodule

// File: tb/tb_usb_rx_packet_parser.sv
// Directed bench for usb_rx_packet_parser: token, SOF, handshake, DATAx payload,
// length limits, bad PID drain and USB bus-reset abort.
module tb_usb_rx_packet_parser;

  logic        clk48_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        usbRst_i = 1'b0;
  logic        rxDataValid_i = 1'b0;
  logic [7:0]  rxData_i = '0;
  logic        rxIsLastByte_i = 1'b0;
  logic        keepPacket_i = 1'b0;
  logic        payReady_i = 1'b1;
  logic        rxAcceptNewData_o;
  logic        tokValid_o;
  logic [3:0]  tokPid_o;
  logic [6:0]  tokAddr_o;
  logic [3:0]  tokEndp_o;
  logic [10:0] sofFrame_o;
  logic        hsValid_o;
  logic [3:0]  hsPid_o;
  logic [3:0]  dataPid_o;
  logic        payValid_o;
  logic [7:0]  payData_o;
  logic        payLast_o;
  logic        pktDone_o;
  logic        pktOk_o;
  logic        pktErr_o;

  usb_rx_packet_parser #(.MAX_PAYLOAD(16)) dut (
    .clk48_i           (clk48_i),
    .rstn_i            (rstn_i),
    .usbRst_i          (usbRst_i),
    .rxAcceptNewData_o (rxAcceptNewData_o),
    .rxDataValid_i     (rxDataValid_i),
    .rxData_i          (rxData_i),
    .rxIsLastByte_i    (rxIsLastByte_i),
    .keepPacket_i      (keepPacket_i),
    .tokValid_o        (tokValid_o),
    .tokPid_o          (tokPid_o),
    .tokAddr_o         (tokAddr_o),
    .tokEndp_o         (tokEndp_o),
    .sofFrame_o        (sofFrame_o),
    .hsValid_o         (hsValid_o),
    .hsPid_o           (hsPid_o),
    .dataPid_o         (dataPid_o),
    .payValid_o        (payValid_o),
    .payReady_i        (payReady_i),
    .payData_o         (payData_o),
    .payLast_o         (payLast_o),
    .pktDone_o         (pktDone_o),
    .pktOk_o           (pktOk_o),
    .pktErr_o          (pktErr_o)
  );

  always #10 clk48_i = ~clk48_i;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Observed events, cleared at the start of each packet.
  int unsigned tok_n, hs_n, done_n, err_n, last_n, last_pos;
  logic        done_ok;
  logic [3:0]  tok_pid_s, hs_pid_s;
  logic [6:0]  tok_addr_s;
  logic [3:0]  tok_endp_s;
  logic [10:0] frame_s;
  logic [7:0]  pay_q[$];
  logic [7:0]  pkt_q[$];
  logic        tgl_en = 1'b0;

  always @(negedge clk48_i) begin
    if (tokValid_o) begin
      tok_n++;
      tok_pid_s  = tokPid_o;
      tok_addr_s = tokAddr_o;
      tok_endp_s = tokEndp_o;
      frame_s    = sofFrame_o;
    end
    if (hsValid_o) begin
      hs_n++;
      hs_pid_s = hsPid_o;
    end
    if (payValid_o && payReady_i) begin
      pay_q.push_back(payData_o);
      if (payLast_o) begin
        last_n++;
        last_pos = pay_q.size();
      end
    end
    if (pktDone_o) begin
      done_n++;
      done_ok = pktOk_o;
    end
    if (pktErr_o) err_n++;
  end

  always @(posedge clk48_i) begin
    #1;
    if (tgl_en) payReady_i = ~payReady_i;
  end

  task automatic clr_mon();
    tok_n = 0; hs_n = 0; done_n = 0; err_n = 0; last_n = 0; last_pos = 0;
    done_ok = 1'b0;
    pay_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic keep);
    int unsigned n;
    n = 0;
    rxDataValid_i  = 1'b1;
    rxData_i       = b;
    rxIsLastByte_i = last;
    keepPacket_i   = keep;
    @(negedge clk48_i);
    while (!rxAcceptNewData_o && n < 200) begin
      @(negedge clk48_i);
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk48_i);
    #1;
    rxDataValid_i  = 1'b0;
    rxIsLastByte_i = 1'b0;
    keepPacket_i   = 1'b0;
  endtask

  task automatic send_pkt(input logic keep);
    clr_mon();
    for (int i = 0; i < pkt_q.size(); i++) send_byte(pkt_q[i], i == pkt_q.size() - 1, keep);
  endtask

  task automatic settle();
    tgl_en = 1'b0;
    payReady_i = 1'b1;
    repeat (12) @(posedge clk48_i);
    #1;
  endtask

  task automatic build_data(input logic [7:0] pid, input int unsigned n, input logic [7:0] first);
    pkt_q.delete();
    pkt_q.push_back(pid);
    for (int unsigned i = 0; i < n; i++) pkt_q.push_back(first + 8'(i));
    pkt_q.push_back(8'hC1);
    pkt_q.push_back(8'hC2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk48_i);
    check("rst_accept", {31'd0, rxAcceptNewData_o}, 32'd0);
    check("rst_outputs", {24'd0, tokValid_o, hsValid_o, payValid_o, payLast_o, pktDone_o, pktOk_o, pktErr_o, 1'b0}, 32'd0);
    @(posedge clk48_i); #1;
    rstn_i = 1'b1;
    repeat (2) @(posedge clk48_i); #1;
    check("idle_accept", {31'd0, rxAcceptNewData_o}, 32'd1);

    pkt_q = '{8'h2D, 8'h05, 8'hE8};
    send_pkt(1'b1); settle();
    check("setup_tok_n", tok_n, 1);
    check("setup_pid", {28'd0, tok_pid_s}, 32'hD);
    check("setup_addr", {25'd0, tok_addr_s}, 32'd5);
    check("setup_endp", {28'd0, tok_endp_s}, 32'd0);
    check("setup_err_n", err_n, 0);

    pkt_q = '{8'h69, 8'h85, 8'h03};
    send_pkt(1'b1); settle();
    check("in_addr", {25'd0, tok_addr_s}, 32'd5);
    check("in_endp", {28'd0, tok_endp_s}, 32'd7);

    pkt_q = '{8'hA5, 8'h34, 8'h12};
    send_pkt(1'b1); settle();
    check("sof_tok_n", tok_n, 1);
    check("sof_pid", {28'd0, tok_pid_s}, 32'h5);
    check("sof_frame", {21'd0, frame_s}, 32'h234);

    pkt_q = '{8'hA5, 8'h34, 8'h12};
    send_pkt(1'b0); settle();
    check("sof_nokeep_tok_n", tok_n, 0);
    check("sof_nokeep_err_n", err_n, 1);

    tgl_en = 1'b1;
    pkt_q = '{8'h4B, 8'h11, 8'h22, 8'h33, 8'hC1, 8'hC2};
    send_pkt(1'b1); settle();
    check("d1_pay_n", pay_q.size(), 3);
    if (pay_q.size() == 3) begin
      check("d1_b0", {24'd0, pay_q[0]}, 32'h11);
      check("d1_b1", {24'd0, pay_q[1]}, 32'h22);
      check("d1_b2", {24'd0, pay_q[2]}, 32'h33);
    end
    check("d1_last_n", last_n, 1);
    check("d1_last_pos", last_pos, 3);
    check("d1_done_n", done_n, 1);
    check("d1_ok", {31'd0, done_ok}, 32'd1);
    check("d1_err_n", err_n, 0);
    check("d1_pid", {28'd0, dataPid_o}, 32'hB);

    build_data(8'h4B, 1, 8'h5A);
    send_pkt(1'b1); settle();
    check("d1_one_pay_n", pay_q.size(), 1);
    check("d1_one_last_pos", last_pos, 1);
    check("d1_one_ok", {31'd0, done_ok}, 32'd1);

    pkt_q = '{8'hC3, 8'hC1, 8'hC2};
    send_pkt(1'b1); settle();
    check("zlp_pay_n", pay_q.size(), 0);
    check("zlp_done_n", done_n, 1);
    check("zlp_ok", {31'd0, done_ok}, 32'd1);
    check("zlp_pid", {28'd0, dataPid_o}, 32'h3);

    send_pkt(1'b0); settle();
    check("zlp_nokeep_done_n", done_n, 1);
    check("zlp_nokeep_ok", {31'd0, done_ok}, 32'd0);
    check("zlp_nokeep_err_n", err_n, 1);

    pkt_q = '{8'hC3, 8'h00};
    send_pkt(1'b1); settle();
    check("short_data_done_n", done_n, 1);
    check("short_data_ok", {31'd0, done_ok}, 32'd0);
    check("short_data_err_n", err_n, 1);

    build_data(8'h87, 8, 8'h01);
    send_pkt(1'b1); settle();
    check("d2_pay_n", pay_q.size(), 8);
    if (pay_q.size() == 8) check("d2_b7", {24'd0, pay_q[7]}, 32'h08);
    check("d2_ok", {31'd0, done_ok}, 32'd1);

    build_data(8'h87, 16, 8'h40);
    send_pkt(1'b1); settle();
    check("max_pay_n", pay_q.size(), 16);
    check("max_last_pos", last_pos, 16);
    check("max_ok", {31'd0, done_ok}, 32'd1);
    check("max_err_n", err_n, 0);

    build_data(8'h87, 17, 8'h40);
    send_pkt(1'b1); settle();
    check("ovf17_pay_n", pay_q.size(), 16);
    check("ovf17_done_n", done_n, 1);
    check("ovf17_ok", {31'd0, done_ok}, 32'd0);
    check("ovf17_err_n", err_n, 1);

    build_data(8'h87, 20, 8'h40);
    send_pkt(1'b1); settle();
    check("ovf20_pay_n", pay_q.size(), 16);
    check("ovf20_last_n", last_n, 0);
    check("ovf20_done_n", done_n, 1);
    check("ovf20_ok", {31'd0, done_ok}, 32'd0);
    check("ovf20_err_n", err_n, 1);

    pkt_q = '{8'hE1, 8'h05};
    send_pkt(1'b1); settle();
    check("tok_short_tok_n", tok_n, 0);
    check("tok_short_err_n", err_n, 1);

    pkt_q = '{8'h2E, 8'h01, 8'h02};
    send_pkt(1'b1); settle();
    check("badpid_err_n", err_n, 1);
    check("badpid_tok_n", tok_n, 0);
    check("badpid_done_n", done_n, 0);

    pkt_q = '{8'hD2};
    send_pkt(1'b1); settle();
    check("ack_hs_n", hs_n, 1);
    check("ack_pid", {28'd0, hs_pid_s}, 32'h2);
    check("ack_err_n", err_n, 0);

    payReady_i = 1'b0;
    clr_mon();
    send_byte(8'hC3, 1'b0, 1'b1);
    send_byte(8'hA1, 1'b0, 1'b1);
    send_byte(8'hA2, 1'b0, 1'b1);
    send_byte(8'hA3, 1'b0, 1'b1);
    send_byte(8'hA4, 1'b0, 1'b1);
    check("rst_mid_pay_valid", {31'd0, payValid_o}, 32'd1);
    check("rst_mid_pay_data", {24'd0, payData_o}, 32'hA1);
    usbRst_i = 1'b1;
    @(posedge clk48_i); #1;
    usbRst_i = 1'b0;
    check("rst_mid_pay_cleared", {31'd0, payValid_o}, 32'd0);
    settle();
    check("rst_mid_done_n", done_n, 0);
    check("rst_mid_err_n", err_n, 0);
    check("rst_mid_pay_n", pay_q.size(), 0);

    pkt_q = '{8'h2D, 8'h7F, 8'h02};
    send_pkt(1'b1); settle();
    check("post_rst_tok_n", tok_n, 1);
    check("post_rst_addr", {25'd0, tok_addr_s}, 32'h7F);
    check("post_rst_endp", {28'd0, tok_endp_s}, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
